// File: rtl/exec_redirect_unit_pkg.sv
// Shared encodings for the execute-side redirect unit: opcodes, branch fn codes,
// NOOP encoding, FSM state type and instruction field helpers.
package exec_redirect_unit_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned FN_W  = 4;
    localparam int unsigned IMM_W = 16;

    localparam logic [OP_W-1:0] OP_ALUR   = 4'h0;
    localparam logic [OP_W-1:0] OP_ALUI   = 4'h1;
    localparam logic [OP_W-1:0] OP_CMPR   = 4'h2;
    localparam logic [OP_W-1:0] OP_CMPI   = 4'h3;
    localparam logic [OP_W-1:0] OP_LOAD   = 4'h4;
    localparam logic [OP_W-1:0] OP_STORE  = 4'h5;
    localparam logic [OP_W-1:0] OP_BRANCH = 4'h6;
    localparam logic [OP_W-1:0] OP_JAL    = 4'h7;
    localparam logic [OP_W-1:0] OP_NOOP   = 4'hF;

    localparam logic [FN_W-1:0] FN_F   = 4'h0;
    localparam logic [FN_W-1:0] FN_EQ  = 4'h1;
    localparam logic [FN_W-1:0] FN_LT  = 4'h2;
    localparam logic [FN_W-1:0] FN_LTE = 4'h3;
    localparam logic [FN_W-1:0] FN_T   = 4'h8;
    localparam logic [FN_W-1:0] FN_NE  = 4'h9;
    localparam logic [FN_W-1:0] FN_GTE = 4'hA;
    localparam logic [FN_W-1:0] FN_GT  = 4'hB;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    function automatic logic [FN_W-1:0] insn_fn(input logic [31:0] insn);
        return insn[31:28];
    endfunction

    function automatic logic [OP_W-1:0] insn_op(input logic [31:0] insn);
        return insn[27:24];
    endfunction

    function automatic logic [IMM_W-1:0] insn_imm(input logic [31:0] insn);
        return insn[15:0];
    endfunction

endpackage

// File: rtl/exec_redirect_unit_if.sv
// Decode-to-execute operand bus plus the redirect outputs fetch consumes.
// Stat counters exist only when BRANCH_STATS_EN is defined.
interface exec_redirect_unit_if #(
    parameter int unsigned DBITS     = 32,
    parameter int unsigned STAT_BITS = 16
);
    logic             inValid;
    logic [DBITS-1:0] instruction;
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] rs1Val;
    logic [DBITS-1:0] rs2Val;
    logic             execStageCmp;
    logic [DBITS-1:0] execStageImm;
    logic [DBITS-1:0] execStageRs1;
    logic             redirectValid;
    logic [DBITS-1:0] redirectTarget;
    logic             linkWrtEn;
    logic [DBITS-1:0] linkValue;
    logic             protoErr;
`ifdef BRANCH_STATS_EN
    logic [STAT_BITS-1:0] statTaken;
    logic [STAT_BITS-1:0] statNotTaken;

    modport master (
        output inValid, instruction, pc, rs1Val, rs2Val,
        input  execStageCmp, execStageImm, execStageRs1, redirectValid,
               redirectTarget, linkWrtEn, linkValue, protoErr, statTaken, statNotTaken
    );
    modport slave (
        input  inValid, instruction, pc, rs1Val, rs2Val,
        output execStageCmp, execStageImm, execStageRs1, redirectValid,
               redirectTarget, linkWrtEn, linkValue, protoErr, statTaken, statNotTaken
    );
`else
    modport master (
        output inValid, instruction, pc, rs1Val, rs2Val,
        input  execStageCmp, execStageImm, execStageRs1, redirectValid,
               redirectTarget, linkWrtEn, linkValue, protoErr
    );
    modport slave (
        input  inValid, instruction, pc, rs1Val, rs2Val,
        output execStageCmp, execStageImm, execStageRs1, redirectValid,
               redirectTarget, linkWrtEn, linkValue, protoErr
    );
`endif
endinterface

// File: rtl/exec_redirect_unit_branch_comparator.sv
// Signed branch condition evaluation; flags fn codes that have no defined compare.
module branch_comparator
    import exec_redirect_unit_pkg::*;
#(
    parameter int unsigned DBITS = 32
) (
    input  logic [FN_W-1:0]  fn,
    input  logic [DBITS-1:0] rs1,
    input  logic [DBITS-1:0] rs2,
    output logic             cmp_c,
    output logic             fn_ok_c
);

    always_comb begin
        cmp_c   = 1'b0;
        fn_ok_c = 1'b1;
        case (fn)
            FN_F:    cmp_c = 1'b0;
            FN_EQ:   cmp_c = (rs1 == rs2);
            FN_LT:   cmp_c = ($signed(rs1) <  $signed(rs2));
            FN_LTE:  cmp_c = ($signed(rs1) <= $signed(rs2));
            FN_T:    cmp_c = 1'b1;
            FN_NE:   cmp_c = (rs1 != rs2);
            FN_GTE:  cmp_c = ($signed(rs1) >= $signed(rs2));
            FN_GT:   cmp_c = ($signed(rs1) >  $signed(rs2));
            default: fn_ok_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_redirect_unit.sv
// Execute-side branch/JAL resolver driving the fetch redirect interface.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module exec_redirect_unit
    import exec_redirect_unit_pkg::*;
#(
    parameter int unsigned DBITS       = 32,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned STAT_BITS   = 16
) (
    input logic               clk,
    input logic               reset,
    exec_redirect_unit_if.slave bus
);

    localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] hold_cnt;

    logic [OP_W-1:0]  op;
    logic [FN_W-1:0]  fn;
    logic [DBITS-1:0] imm_sext;
    logic [DBITS-1:0] offset;
    logic [DBITS-1:0] pc4;
    logic             cmp_c;
    logic             fn_ok_c;
    logic             accept;
    logic             is_br;
    logic             is_jal;
    logic             hold_violation;
    logic             taken;
    logic             unused_fields;

    assign op       = insn_op(bus.instruction[31:0]);
    assign fn       = insn_fn(bus.instruction[31:0]);
    assign imm_sext = {{(DBITS-IMM_W){bus.instruction[IMM_W-1]}}, insn_imm(bus.instruction[31:0])};
    assign offset   = imm_sext << 2;
    assign pc4      = bus.pc + DBITS'(4);
    assign is_br    = (op == OP_BRANCH);
    assign is_jal   = (op == OP_JAL);
    assign taken    = is_jal | cmp_c;
    assign unused_fields = ^bus.instruction[23:16];

    // A new instruction is taken in IDLE or on the final HOLD cycle (back-to-back).
    assign accept         = bus.inValid && ((state == S_IDLE) || (hold_cnt == '0));
    assign hold_violation = bus.inValid && !accept && (op != OP_NOOP);

    branch_comparator #(.DBITS(DBITS)) u_cmp (
        .fn      (fn),
        .rs1     (bus.rs1Val),
        .rs2     (bus.rs2Val),
        .cmp_c   (cmp_c),
        .fn_ok_c (fn_ok_c)
    );

    // Redirect outputs are captured only when HOLD is entered and held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= S_IDLE;
            hold_cnt           <= '0;
            bus.execStageCmp   <= 1'b0;
            bus.execStageImm   <= '0;
            bus.execStageRs1   <= '0;
            bus.redirectValid  <= 1'b0;
            bus.redirectTarget <= '0;
            bus.linkWrtEn      <= 1'b0;
            bus.linkValue      <= '0;
            bus.protoErr       <= 1'b0;
`ifdef BRANCH_STATS_EN
            bus.statTaken      <= '0;
            bus.statNotTaken   <= '0;
`endif
        end else begin
            bus.linkWrtEn <= 1'b0;
            if (hold_violation) begin
                bus.protoErr <= 1'b1;
            end
            if (accept && (is_br || is_jal)) begin
                state              <= S_HOLD;
                hold_cnt           <= CNT_INIT;
                bus.redirectValid  <= 1'b1;
                bus.execStageCmp   <= taken;
                bus.execStageImm   <= imm_sext;
                bus.execStageRs1   <= bus.rs1Val;
                bus.redirectTarget <= is_jal ? (bus.rs1Val + offset)
                                             : (cmp_c ? (pc4 + offset) : pc4);
                if (is_jal) begin
                    bus.linkWrtEn <= 1'b1;
                    bus.linkValue <= pc4;
                end
                if (is_br && !fn_ok_c) begin
                    bus.protoErr <= 1'b1;
                end
`ifdef BRANCH_STATS_EN
                if (taken && (bus.statTaken != '1)) begin
                    bus.statTaken <= bus.statTaken + STAT_BITS'(1);
                end
                if (!taken && (bus.statNotTaken != '1)) begin
                    bus.statNotTaken <= bus.statNotTaken + STAT_BITS'(1);
                end
`endif
            end else if (state == S_HOLD) begin
                if (hold_cnt == '0) begin
                    state             <= S_IDLE;
                    bus.redirectValid <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_redirect_unit.sv
// Directed bench for exec_redirect_unit: a window-count reference model checked
// every falling edge, plus literal expectations for the key scenarios.
module tb_exec_redirect_unit;
    import exec_redirect_unit_pkg::*;

    localparam int unsigned DBITS = 32;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned SBITS = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    exec_redirect_unit_if #(.DBITS(DBITS), .STAT_BITS(SBITS)) bus ();

    exec_redirect_unit #(.DBITS(DBITS), .HOLD_CYCLES(HOLD), .STAT_BITS(SBITS)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference branch condition straight from the fn table.
    function automatic logic ref_cond(input logic [3:0] f, input logic signed [31:0] a,
                                      input logic signed [31:0] b, output logic ok);
        ok = 1'b1;
        case (f)
            4'd0:    return 1'b0;
            4'd1:    return a == b;
            4'd2:    return a < b;
            4'd3:    return a <= b;
            4'd8:    return 1'b1;
            4'd9:    return a != b;
            4'd10:   return a >= b;
            4'd11:   return a > b;
            default: begin ok = 1'b0; return 1'b0; end
        endcase
    endfunction

    // Model tracks how many redirect-valid cycles remain in the current window.
    logic        m_valid, m_cmp, m_link_en, m_err;
    logic [31:0] m_imm, m_rs1, m_target, m_link;
    int          m_left;
    int unsigned m_taken, m_ntaken;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_cmp <= 1'b0; m_link_en <= 1'b0; m_err <= 1'b0;
            m_imm <= '0; m_rs1 <= '0; m_target <= '0; m_link <= '0;
            m_left <= 0; m_taken <= 0; m_ntaken <= 0;
        end else begin
            logic [3:0]  op, f;
            logic [31:0] sx, off;
            logic        tk, ok;
            int          left;
            left = (m_left > 0) ? m_left - 1 : 0;
            m_link_en <= 1'b0;
            if (bus.inValid) begin
                op  = bus.instruction[27:24];
                f   = bus.instruction[31:28];
                sx  = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
                off = sx * 4;
                if (m_left > 1) begin
                    if (op != OP_NOOP) m_err <= 1'b1;
                end else if (op == OP_BRANCH || op == OP_JAL) begin
                    if (op == OP_JAL) begin
                        tk = 1'b1;
                        m_target  <= bus.rs1Val + off;
                        m_link_en <= 1'b1;
                        m_link    <= bus.pc + 4;
                    end else begin
                        tk = ref_cond(f, bus.rs1Val, bus.rs2Val, ok);
                        m_target <= tk ? bus.pc + 4 + off : bus.pc + 4;
                        if (!ok) m_err <= 1'b1;
                    end
                    m_cmp <= tk;
                    m_imm <= sx;
                    m_rs1 <= bus.rs1Val;
                    left  = HOLD;
                    if (tk) m_taken <= m_taken + 1;
                    else    m_ntaken <= m_ntaken + 1;
                end
            end
            m_left  <= left;
            m_valid <= (left > 0);
        end
    end

    always @(negedge clk) begin
        chk("m_valid",  bus.redirectValid,  m_valid);
        chk("m_cmp",    bus.execStageCmp,   m_cmp);
        chk("m_imm",    bus.execStageImm,   m_imm);
        chk("m_rs1",    bus.execStageRs1,   m_rs1);
        chk("m_target", bus.redirectTarget, m_target);
        chk("m_linken", bus.linkWrtEn,      m_link_en);
        chk("m_link",   bus.linkValue,      m_link);
        chk("m_err",    bus.protoErr,       m_err);
`ifdef BRANCH_STATS_EN
        chk("m_stat_t",  32'(bus.statTaken),    m_taken);
        chk("m_stat_nt", 32'(bus.statNotTaken), m_ntaken);
`endif
    end

    task automatic drive(input logic [3:0] op, input logic [3:0] f, input logic [15:0] imm,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.inValid     = 1'b1;
        bus.instruction = {f, op, 8'h00, imm};
        bus.pc          = pc;
        bus.rs1Val      = a;
        bus.rs2Val      = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.inValid = 1'b0;
        end
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  fns [8]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
    logic [31:0] va  [3]  = '{32'd3, 32'hFFFFFFFB, 32'd4};
    logic [31:0] vb  [3]  = '{32'd3, 32'd4, 32'hFFFFFFFB};

    initial begin
        bus.inValid = 1'b0; bus.instruction = '0; bus.pc = '0; bus.rs1Val = '0; bus.rs2Val = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid",  bus.redirectValid,  0);
        chk("rst_target", bus.redirectTarget, 0);
        chk("rst_err",    bus.protoErr,       0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // BEQ taken, window exactly two cycles
        drive(OP_BRANCH, FN_EQ, 16'd3, 32'h40, 32'd5, 32'd5);
        after_edge;
        chk("beq_cmp", bus.execStageCmp, 1);
        chk("beq_target", bus.redirectTarget, 32'h50);
        chk("beq_valid1", bus.redirectValid, 1);
        idle(1); after_edge;
        chk("beq_valid2", bus.redirectValid, 1);
        after_edge;
        chk("beq_valid_end", bus.redirectValid, 0);
        chk("beq_cmp_kept", bus.execStageCmp, 1);

        // BLT not taken, then signed-taken
        drive(OP_BRANCH, FN_LT, 16'hFFFC, 32'h40, 32'd7, 32'd2);
        after_edge;
        chk("blt_nt_cmp", bus.execStageCmp, 0);
        chk("blt_nt_target", bus.redirectTarget, 32'h44);
        chk("blt_imm", bus.execStageImm, 32'hFFFFFFFC);
        idle(2);
        drive(OP_BRANCH, FN_LT, 16'hFFFC, 32'h40, 32'hFFFFFFFF, 32'd2);
        after_edge;
        chk("blt_t_cmp", bus.execStageCmp, 1);
        chk("blt_t_target", bus.redirectTarget, 32'h34);

        // JAL with one-cycle link pulse
        idle(2);
        drive(OP_JAL, FN_F, 16'd1, 32'h100, 32'h200, 32'd0);
        after_edge;
        chk("jal_target", bus.redirectTarget, 32'h204);
        chk("jal_link", bus.linkValue, 32'h104);
        chk("jal_linken1", bus.linkWrtEn, 1);
        chk("jal_cmp", bus.execStageCmp, 1);
        idle(1); after_edge;
        chk("jal_linken2", bus.linkWrtEn, 0);
        chk("jal_valid2", bus.redirectValid, 1);

        // back-to-back: second branch lands on the last HOLD edge
        idle(1);
        drive(OP_BRANCH, FN_NE, 16'd8, 32'h200, 32'd1, 32'd2);
        after_edge;
        chk("b2b_first", bus.redirectTarget, 32'h224);
        idle(1);
        drive(OP_BRANCH, FN_GT, 16'd2, 32'h300, 32'd3, 32'd9);
        after_edge;
        chk("b2b_target", bus.redirectTarget, 32'h304);
        chk("b2b_valid", bus.redirectValid, 1);
        chk("b2b_noerr", bus.protoErr, 0);
        idle(1); after_edge;
        chk("b2b_valid2", bus.redirectValid, 1);
        after_edge;
        chk("b2b_end", bus.redirectValid, 0);

        // NOOP in HOLD is silent, ALUR in HOLD is a sticky error
        drive(OP_BRANCH, FN_EQ, 16'd1, 32'h10, 32'd0, 32'd0);
        drive(OP_NOOP, FN_F, 16'd0, 32'h999, 32'd0, 32'd0);
        after_edge;
        chk("noop_noerr", bus.protoErr, 0);
        chk("noop_target", bus.redirectTarget, 32'h18);
        idle(1);
        drive(OP_BRANCH, FN_EQ, 16'd0, 32'h20, 32'd0, 32'd0);
        drive(OP_ALUR, FN_F, 16'd0, 32'h999, 32'd0, 32'd0);
        after_edge;
        chk("alur_err", bus.protoErr, 1);
        chk("alur_ignored", bus.redirectTarget, 32'h24);
        idle(3); after_edge;
        chk("err_sticky", bus.protoErr, 1);

        // undefined fn, non-branch in IDLE, address wrap
        drive(OP_BRANCH, 4'h4, 16'd5, 32'h80, 32'd1, 32'd1);
        after_edge;
        chk("undef_cmp", bus.execStageCmp, 0);
        chk("undef_target", bus.redirectTarget, 32'h84);
        idle(2);
        drive(OP_ALUI, FN_EQ, 16'd9, 32'h500, 32'd1, 32'd1);
        after_edge;
        chk("alui_valid", bus.redirectValid, 0);
        chk("alui_target", bus.redirectTarget, 32'h84);
        idle(1);
        drive(OP_BRANCH, FN_T, 16'h7FFF, 32'hFFFFFFF0, 32'd0, 32'd0);
        after_edge;
        chk("wrap_target", bus.redirectTarget, 32'h0001FFF0);
        idle(2);

        // every fn code against equal / less / greater signed operands
        foreach (fns[i]) begin
            foreach (va[j]) begin
                drive(OP_BRANCH, fns[i], 16'(i * 3 + j), 32'h1000, va[j], vb[j]);
                idle(2);
            end
        end

        // async reset in the middle of a HOLD window
        drive(OP_BRANCH, FN_EQ, 16'd2, 32'h60, 32'd1, 32'd1);
        after_edge;
        #2 rst_n = 1'b0;
        #1;
        chk("rsthold_valid", bus.redirectValid, 0);
        chk("rsthold_cmp", bus.execStageCmp, 0);
        chk("rsthold_target", bus.redirectTarget, 0);
        chk("rsthold_err", bus.protoErr, 0);
        idle(1);
        rst_n = 1'b1;
        after_edge;
        chk("rsthold_idle", bus.redirectValid, 0);

`ifdef BRANCH_STATS_EN
        drive(OP_BRANCH, FN_EQ, 16'd1, 32'h0, 32'd1, 32'd1); idle(2);
        drive(OP_BRANCH, FN_F,  16'd1, 32'h0, 32'd1, 32'd1); idle(2);
        drive(OP_BRANCH, FN_T,  16'd1, 32'h0, 32'd1, 32'd1); idle(2);
        drive(OP_BRANCH, FN_NE, 16'd1, 32'h0, 32'd2, 32'd2); idle(2);
        drive(OP_BRANCH, FN_GT, 16'd1, 32'h0, 32'd5, 32'd1); idle(2);
        after_edge;
        chk("stat_taken", 32'(bus.statTaken), 3);
        chk("stat_not_taken", 32'(bus.statNotTaken), 2);
`endif

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
